// File: rtl/md5_pkg.sv
// Shared widths and match-detector state encoding for the MD5 hash-breaker datapath.
package md5_pkg;

    localparam int unsigned MD5_HASH_W  = 128;
    localparam int unsigned MD5_BLOCK_W = 512;
    localparam int unsigned MD5_MSG_W   = 448;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEARCH    = 3'd1,
        DRAIN     = 3'd2,
        FOUND     = 3'd3,
        EXHAUSTED = 3'd4
    } md5_state_t;

endpackage

// File: rtl/md5_hash_cmp.sv
// Registered 128-bit equality compare, split into NCHUNK equal slices so each
// slice comparator stays short; the final AND of slice bits happens one stage later.
module md5_hash_cmp
    import md5_pkg::*;
#(
    parameter int unsigned NCHUNK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic [MD5_HASH_W-1:0] hash,
    input  logic [MD5_HASH_W-1:0] target,
    output logic [NCHUNK-1:0]     eq,
    output logic                  valid_out
);

    localparam int unsigned SLICE_W = MD5_HASH_W / NCHUNK;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eq        <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= valid_in && !flush;
            for (int unsigned i = 0; i < NCHUNK; i++) begin
                eq[i] <= (hash[i*SLICE_W +: SLICE_W] == target[i*SLICE_W +: SLICE_W]);
            end
        end
    end

endmodule

// File: rtl/md5_match_detector.sv
// Consumes one (hash, message) pair per clock from the MD5 core, captures the first
// candidate whose hash equals the armed target, and tracks candidates checked against a limit.
module md5_match_detector
    import md5_pkg::*;
#(
    parameter int unsigned CNT_W  = 48,
    parameter int unsigned NCHUNK = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [MD5_HASH_W-1:0]  target_hash,
    input  logic [CNT_W-1:0]       limit,
    input  logic                   in_valid,
    input  logic [MD5_HASH_W-1:0]  hash,
    input  logic [MD5_BLOCK_W-1:0] message_out,
    output logic                   busy,
    output logic                   found,
    output logic                   exhausted,
    output logic [MD5_BLOCK_W-1:0] match_message,
    output logic [CNT_W-1:0]       checked_count
);

    md5_state_t             state;
    md5_state_t             state_next;
    logic [MD5_HASH_W-1:0]  target_q;
    logic [CNT_W-1:0]       limit_q;
    logic [CNT_W-1:0]       count_inc;

    logic                   s0_valid;
    logic [MD5_HASH_W-1:0]  s0_hash;
    logic [MD5_BLOCK_W-1:0] s0_msg;
    logic                   s1_valid;
    logic [NCHUNK-1:0]      s1_eq;
    logic [MD5_BLOCK_W-1:0] s1_msg;

    logic                   arm;
    logic                   accept;
    logic                   match;
    logic                   limit_hit;

    assign busy      = (state == SEARCH) || (state == DRAIN);
    assign found     = (state == FOUND);
    assign exhausted = (state == EXHAUSTED);

    // A match is only honoured while a search is live, so candidates still in
    // flight after FOUND can never overwrite the captured message.
    assign arm       = start && !busy;
    assign accept    = (state == SEARCH) && in_valid;
    assign match     = s1_valid && (&s1_eq) && busy;
    assign count_inc = (&checked_count) ? checked_count : checked_count + CNT_W'(1);
    assign limit_hit = accept && (limit_q != '0) && (count_inc == limit_q);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, FOUND, EXHAUSTED: if (start) state_next = SEARCH;
            SEARCH: begin
                if (match)          state_next = FOUND;
                else if (limit_hit) state_next = DRAIN;
            end
            DRAIN: begin
                if (match)                      state_next = FOUND;
                else if (!s0_valid && !s1_valid) state_next = EXHAUSTED;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            target_q      <= '0;
            limit_q       <= '0;
            checked_count <= '0;
            s0_valid      <= 1'b0;
        end else begin
            state <= state_next;
            if (arm) begin
                target_q      <= target_hash;
                limit_q       <= limit;
                checked_count <= '0;
            end else if (accept) begin
                checked_count <= count_inc;
            end
            // accept is only possible in SEARCH, so an arming start clears S0 here too
            s0_valid <= accept;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_hash       <= '0;
            s0_msg        <= '0;
            s1_msg        <= '0;
            match_message <= '0;
        end else begin
            if (accept) begin
                s0_hash <= hash;
                s0_msg  <= message_out;
            end
            if (s0_valid) begin
                s1_msg <= s0_msg;
            end
            if (match) begin
                match_message <= s1_msg;
            end
        end
    end

    md5_hash_cmp #(
        .NCHUNK (NCHUNK)
    ) u_cmp (
        .clk       (clk),
        .rst       (rst),
        .flush     (arm),
        .valid_in  (s0_valid),
        .hash      (s0_hash),
        .target    (target_q),
        .eq        (s1_eq),
        .valid_out (s1_valid)
    );

endmodule

// File: tb/tb_md5_match_detector.sv
// Self-checking bench for md5_match_detector: directed scenarios plus randomized
// traffic, compared every cycle against a transaction-level model of the detector.
module tb_md5_match_detector;
    import md5_pkg::*;

    localparam int unsigned CNT_W = 48;

    localparam logic [127:0] T1 = 128'h098f6bcd4621d373cade4e832627b4f6;
    localparam logic [127:0] T2 = 128'hd41d8cd98f00b204e9800998ecf8427e;
    localparam logic [127:0] T3 = 128'h5d41402abc4b2a76b9719d911017c592;
    localparam logic [511:0] TEST_M = {32'h74657374, 8'h80, 408'h0, 8'h20, 56'h0};

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [127:0]   target_hash = '0;
    logic [CNT_W-1:0] limit = '0;
    logic           in_valid = 1'b0;
    logic [127:0]   hash = '0;
    logic [511:0]   message_out = '0;
    logic           busy, found, exhausted;
    logic [511:0]   match_message;
    logic [CNT_W-1:0] checked_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    md5_match_detector #(
        .CNT_W  (CNT_W),
        .NCHUNK (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .target_hash   (target_hash),
        .limit         (limit),
        .in_valid      (in_valid),
        .hash          (hash),
        .message_out   (message_out),
        .busy          (busy),
        .found         (found),
        .exhausted     (exhausted),
        .match_message (match_message),
        .checked_count (checked_count)
    );

    // Model: a search is a list of accepted candidates, each resolving two edges after acceptance.
    typedef struct {
        logic [511:0]    msg;
        bit              hit;
        longint unsigned due;
    } cand_t;

    cand_t            inflight[$];
    bit               m_busy = 0, m_acc = 0, m_found = 0, m_exh = 0;
    logic [127:0]     m_tgt = '0;
    logic [CNT_W-1:0] m_lim = '0, m_cnt = '0;
    logic [511:0]     m_msg = '0;
    longint unsigned  edge_n = 0;

    task automatic model_reset();
        m_busy = 0; m_acc = 0; m_found = 0; m_exh = 0;
        m_tgt = '0; m_lim = '0; m_cnt = '0; m_msg = '0;
        inflight.delete();
    endtask

    task automatic model_step();
        bit    pre_busy, pre_acc, pre_empty, hit_now;
        cand_t c;
        edge_n++;
        pre_busy  = m_busy;
        pre_acc   = m_acc;
        pre_empty = (inflight.size() == 0);
        hit_now   = 0;
        while (inflight.size() != 0 && inflight[0].due <= edge_n) begin
            c = inflight.pop_front();
            if (pre_busy && c.hit && !hit_now) begin
                hit_now = 1;
                m_msg   = c.msg;
            end
        end
        if (hit_now) begin
            m_found = 1; m_busy = 0; m_acc = 0;
            inflight.delete();
        end
        if (start && !pre_busy) begin
            m_tgt = target_hash; m_lim = limit; m_cnt = '0;
            m_found = 0; m_exh = 0; m_busy = 1; m_acc = 1;
            inflight.delete();
        end
        if (pre_acc && in_valid) begin
            if (m_cnt != '1) m_cnt = m_cnt + 48'd1;
            if (!hit_now) begin
                c.msg = message_out;
                c.hit = (hash == m_tgt);
                c.due = edge_n + 2;
                inflight.push_back(c);
                if (m_lim != '0 && m_cnt == m_lim) m_acc = 0;
            end
        end
        if (pre_busy && !pre_acc && pre_empty && !hit_now) begin
            m_exh = 1; m_busy = 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    task automatic compare_cycle();
        vectors++;
        if (busy !== m_busy || found !== m_found || exhausted !== m_exh ||
            checked_count !== m_cnt || match_message !== m_msg) begin
            miscompares++;
            $display("FAIL cycle_cmp @%0t: busy %b exp %b, found %b exp %b, exhausted %b exp %b, count %0d exp %0d, msg %h exp %h",
                     $time, busy, m_busy, found, m_found, exhausted, m_exh,
                     checked_count, m_cnt, match_message, m_msg);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_msg(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are compared on the falling edge.
    task automatic tick();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic arm(input logic [127:0] t, input logic [CNT_W-1:0] l);
        start = 1'b1; target_hash = t; limit = l;
        tick();
    endtask

    task automatic feed(input logic [127:0] h, input logic [511:0] m);
        in_valid = 1'b1; hash = h; message_out = m;
        tick();
    endtask

    function automatic logic [127:0] rnd128();
        logic [127:0] v;
        for (int i = 0; i < 4; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    logic [511:0] m_a, m_b, m_e, m_g, m_s;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_found", 64'(found), 64'd0);
        chk("reset_count", 64'(checked_count), 64'd0);
        chk_msg("reset_msg", match_message, '0);
        rst = 1'b0;
        tick();

        // Match on the 3rd candidate
        arm(T1, '0);
        feed(rnd128(), rnd512());
        feed(rnd128(), rnd512());
        feed(T1, TEST_M);
        chk("match_count_e0", 64'(checked_count), 64'd3);
        tick();
        chk("match_found_e1", 64'(found), 64'd0);
        tick();
        chk("match_found_e2", 64'(found), 64'd1);
        chk("match_busy", 64'(busy), 64'd0);
        chk("match_count", 64'(checked_count), 64'd3);
        chk_msg("match_msg", match_message, TEST_M);

        // Exhaust after five misses
        arm(T2, 48'd5);
        for (int i = 0; i < 5; i++) feed(rnd128(), rnd512());
        chk("exh_count5", 64'(checked_count), 64'd5);
        chk("exh_busy_drain", 64'(busy), 64'd1);
        feed(rnd128(), rnd512());
        feed(rnd128(), rnd512());
        chk("exh_not_yet", 64'(exhausted), 64'd0);
        feed(rnd128(), rnd512());
        chk("exh_set", 64'(exhausted), 64'd1);
        chk("exh_found", 64'(found), 64'd0);
        feed(rnd128(), rnd512());
        chk("exh_count_hold", 64'(checked_count), 64'd5);

        // Match on the final allowed candidate
        arm(T1, 48'd5);
        for (int i = 0; i < 4; i++) feed(rnd128(), rnd512());
        m_s = rnd512();
        feed(T1, m_s);
        feed(rnd128(), rnd512());
        feed(rnd128(), rnd512());
        chk("bound_found", 64'(found), 64'd1);
        chk("bound_exh", 64'(exhausted), 64'd0);
        chk("bound_count", 64'(checked_count), 64'd5);
        tick();
        tick();
        chk("bound_exh_later", 64'(exhausted), 64'd0);
        chk_msg("bound_msg", match_message, m_s);

        // Back-to-back matches, then re-arm with old matches in flight
        m_a = rnd512(); m_b = rnd512(); m_e = rnd512();
        arm(T1, '0);
        feed(rnd128(), rnd512());
        feed(T1, m_a);
        feed(T1, m_b);
        feed(T1, rnd512());
        chk("b2b_found", 64'(found), 64'd1);
        chk("b2b_count", 64'(checked_count), 64'd4);
        chk_msg("b2b_msg_first", match_message, m_a);
        arm(T3, '0);
        chk("rearm_found_clr", 64'(found), 64'd0);
        chk("rearm_busy", 64'(busy), 64'd1);
        chk("rearm_count0", 64'(checked_count), 64'd0);
        for (int i = 0; i < 3; i++) feed(T1, rnd512());
        chk("rearm_no_false", 64'(found), 64'd0);
        chk("rearm_count3", 64'(checked_count), 64'd3);
        feed(T3, m_e);
        tick();
        tick();
        chk("rearm_found_new", 64'(found), 64'd1);
        chk_msg("rearm_msg", match_message, m_e);

        // start while searching is ignored
        m_g = rnd512();
        arm(T1, '0);
        feed(rnd128(), rnd512());
        feed(rnd128(), rnd512());
        start = 1'b1; target_hash = T2; limit = 48'd1;
        in_valid = 1'b1; hash = rnd128(); message_out = rnd512();
        tick();
        chk("ign_count", 64'(checked_count), 64'd3);
        chk("ign_busy", 64'(busy), 64'd1);
        feed(T1, m_g);
        tick();
        tick();
        chk("ign_found_old_tgt", 64'(found), 64'd1);
        chk("ign_count_final", 64'(checked_count), 64'd4);
        chk_msg("ign_msg", match_message, m_g);

        // Reset with a match sitting in S1
        arm(T1, '0);
        feed(T1, rnd512());
        tick();
        rst = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_found", 64'(found), 64'd0);
        chk("rst_count", 64'(checked_count), 64'd0);
        chk_msg("rst_msg", match_message, '0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_found_never", 64'(found), 64'd0);

        // Randomized traffic checked against the model every cycle
        for (int s = 0; s < 30; s++) begin
            int unsigned n;
            arm(rnd128(), CNT_W'($urandom_range(0, 6)));
            n = $urandom_range(6, 24);
            for (int unsigned k = 0; k < n; k++) begin
                in_valid    = ($urandom_range(0, 3) != 0);
                hash        = ($urandom_range(0, 6) == 0) ? m_tgt : rnd128();
                message_out = rnd512();
                if ($urandom_range(0, 15) == 0) begin
                    start       = 1'b1;
                    target_hash = rnd128();
                    limit       = CNT_W'($urandom_range(0, 3));
                end
                if ($urandom_range(0, 99) == 0) rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
